aes_round_sequencer: RTL
========================

Name: aes_round_sequencer

Overview:
Parametrised iterative AES control block. It accepts a block, key and direction over a valid/ready handshake. It then drives an external single-round datapath core once per round for NR rounds and returns the result over a valid/ready handshake with backpressure. It supports 128/192/256-bit keys, encrypt and decrypt, a configurable core latency, and protocol-error detection, none of which the earlier fixed AES-128 top controller had.

Parameters:
KEY_W, 128, key width; legal values 128, 192, 256; anything else is an elaboration error
NR, KEY_W/32+6, round count (10/12/14); derived localparam, not overridable
RND_W, 4, width of the round index bus
DATA_W, 128, block width; fixed at 128, parameter kept for bus sizing only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept a request
in_data  in  DATA_W  plaintext or ciphertext
in_key  in  KEY_W  cipher key
in_dec  in  1  0 = encrypt, 1 = decrypt
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  result block
busy  out  1  high in any state other than IDLE
core_start  out  1  one-cycle pulse launching one round
core_first  out  1  qualifies core_start: first round (includes initial AddRoundKey)
core_last  out  1  qualifies core_start: final round (no (Inv)MixColumns)
core_dec  out  1  direction latched at accept
core_round  out  RND_W  round index 1..NR
core_din  out  DATA_W  working state presented to the core
core_key  out  KEY_W  latched key
core_done  in  1  one-cycle pulse; core_dout valid in that cycle
core_dout  in  DATA_W  round result
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - core_start=0, core_first=0, core_last=0, core_dec=0
  - core_round=0, proto_err=0
  - out_data, core_din and core_key cleared to 0
- Reset mid-operation: the operation is abandoned; no out_valid is ever produced for it.
- State machine: IDLE, LAUNCH, WAIT, OUT. All outputs are registered.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready: latch in_data into the working register, latch in_key and in_dec, set round=1, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - core_start=1.
  - core_first = (round==1); core_last = (round==NR).
  - Go to WAIT.
- WAIT:
  - Hold core_din, core_key, core_dec and core_round stable.
  - On core_done, capture core_dout into the working register.
  - If round==NR: out_data <= core_dout, go to OUT.
  - Otherwise: round++, go to LAUNCH.
- OUT:
  - out_valid=1; out_data is held stable until out_valid & out_ready, then go to IDLE.
  - in_ready=0 in OUT, so a new request is accepted no earlier than the cycle after the handshake.
- Latency, with core latency L ≥ 1 (cycles from core_start to core_done):
  - accept at cycle 0, first core_start at cycle 1, round period L+1
  - out_valid at cycle 1+NR*(L+1); 128-bit key with L=1 gives cycle 21.
- core_done arriving in IDLE, LAUNCH or OUT: ignored for data, sets proto_err=1.
- core_done in the same cycle as core_start: not a legal core response; treated as spurious, sets proto_err.
- proto_err is cleared only by reset.
- in_valid while busy: ignored; the requester holds it until in_ready.
- core_round wraps never: it is bounded 1..NR and returns to 0 in IDLE.

Optional Feature:
AES_SEQ_ABORT_EN. When defined:
- Adds input abort (1 bit).
- abort=1 in LAUNCH or WAIT returns the block to IDLE next cycle: no out_valid, round=0, core_start suppressed.
- A core_done arriving later for the aborted round is ignored and does not set proto_err, for a window of L_MAX=16 cycles.
- abort in IDLE or OUT has no effect; an OUT result still needs out_ready.

When not defined: no abort port, and the block is identical to the description above.

Test Plan:
- FIPS-197 C.1 AES-128 encrypt: key 000102..0f, pt 00112233..ff, behavioural core with L=1 -> out_valid at cycle 21, out_data 69c4e0d86a7b0430d8cdb78070b4c55a, exactly 10 core_start pulses, core_first only on round 1, core_last only on round 10.
- KEY_W=256 decrypt of the C.3 ciphertext 8ea2b7ca516745bfeafc49904b496089 with L=3 -> out_valid at cycle 57, out_data 00112233..ff, core_dec=1 throughout.
- Backpressure: out_ready held 0 for 7 cycles -> out_valid and out_data stable and in_ready=0 throughout; new request accepted the cycle after the handshake.
- Reset (rst=0) pulsed during WAIT of round 5 -> all outputs at reset values immediately; the next request completes normally with the correct result.
- Spurious core_done injected in IDLE -> proto_err=1 and stays 1; a following encryption still produces the correct ciphertext.
- With AES_SEQ_ABORT_EN: abort in WAIT of round 3 -> IDLE next cycle, no out_valid, the late core_done does not set proto_err; the next vector passes.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: accepts a block/key/direction, drives an external
// single-round core NR times, returns the result. AES_SEQ_ABORT_EN adds an abort input.
module aes_round_sequencer #(
  parameter int KEY_W  = 128,
  parameter int RND_W  = 4,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  in_key,
  input  logic              in_dec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              core_start,
  output logic              core_first,
  output logic              core_last,
  output logic              core_dec,
  output logic [RND_W-1:0]  core_round,
  output logic [DATA_W-1:0] core_din,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout,
`ifdef AES_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              proto_err
);

  localparam int NR = KEY_W / 32 + 6;
  localparam logic [RND_W-1:0] FIRST_RND = RND_W'(1);
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NR);

  if (KEY_W != 128 && KEY_W != 192 && KEY_W != 256) begin : g_bad_key_w
    $error("aes_round_sequencer: KEY_W must be 128, 192 or 256");
  end
  if (DATA_W != 128) begin : g_bad_data_w
    $error("aes_round_sequencer: DATA_W must be 128");
  end
  if ((1 << RND_W) <= NR) begin : g_bad_rnd_w
    $error("aes_round_sequencer: RND_W too narrow for NR");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               dec_q, dec_d;
  logic               start_q, start_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic               perr_q, perr_d;
  logic               done_eff;

`ifdef AES_SEQ_ABORT_EN
  localparam int L_MAX = 16;
  logic               stale_q, stale_d;
  logic [4:0]         stale_cnt_q, stale_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    work_d     = work_q;
    key_d      = key_q;
    dec_d      = dec_q;
    out_data_d = out_data_q;
    perr_d     = perr_q;
    start_d    = 1'b0;
    done_eff   = core_done;
`ifdef AES_SEQ_ABORT_EN
    // After an abort the core still owes one completion; swallow it within L_MAX cycles.
    stale_d     = stale_q;
    stale_cnt_d = stale_cnt_q;
    if (stale_q) begin
      stale_cnt_d = stale_cnt_q - 5'd1;
      if (stale_cnt_q == 5'd1) stale_d = 1'b0;
      if (core_done) begin
        done_eff = 1'b0;
        stale_d  = 1'b0;
      end
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (done_eff) perr_d = 1'b1;
        if (in_valid && in_ready_q) begin
          work_d  = in_data;
          key_d   = in_key;
          dec_d   = in_dec;
          round_d = FIRST_RND;
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // A completion while core_start is still high cannot belong to this launch.
        if (done_eff) perr_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_eff) begin
          work_d = core_dout;
          if (round_q == LAST_RND) begin
            out_data_d = core_dout;
            state_d    = S_OUT;
          end else begin
            round_d = round_q + FIRST_RND;
            start_d = 1'b1;
            state_d = S_LAUNCH;
          end
        end
      end
      S_OUT: begin
        if (done_eff) perr_d = 1'b1;
        if (out_ready) begin
          round_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef AES_SEQ_ABORT_EN
    if (abort && (state_q == S_LAUNCH || state_q == S_WAIT)) begin
      state_d = S_IDLE;
      round_d = '0;
      start_d = 1'b0;
      if (!(state_q == S_WAIT && core_done)) begin
        stale_d     = 1'b1;
        stale_cnt_d = 5'(L_MAX);
      end
    end
`endif
    first_d     = start_d && (round_d == FIRST_RND);
    last_d      = start_d && (round_d == LAST_RND);
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      work_q      <= '0;
      key_q       <= '0;
      dec_q       <= 1'b0;
      out_data_q  <= '0;
      start_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      perr_q      <= 1'b0;
`ifdef AES_SEQ_ABORT_EN
      stale_q     <= 1'b0;
      stale_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      work_q      <= work_d;
      key_q       <= key_d;
      dec_q       <= dec_d;
      out_data_q  <= out_data_d;
      start_q     <= start_d;
      first_q     <= first_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      perr_q      <= perr_d;
`ifdef AES_SEQ_ABORT_EN
      stale_q     <= stale_d;
      stale_cnt_q <= stale_cnt_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign core_start = start_q;
  assign core_first = first_q;
  assign core_last  = last_q;
  assign core_dec   = dec_q;
  assign core_round = round_q;
  assign core_din   = work_q;
  assign core_key   = key_q;
  assign proto_err  = perr_q;

endmodule
